// File: rtl/obi_mem_tester_if.sv
// rtl/obi_mem_tester_if.sv - OBI manager/subordinate bus bundle for the memory tester
interface obi_mem_tester_if #(
  parameter int AddrWidth = 48,
  parameter int DataWidth = 512,
  parameter int IdWidth   = 3
);
  logic                   req;
  logic                   gnt;
  logic [AddrWidth-1:0]   addr;
  logic                   we;
  logic [DataWidth/8-1:0] be;
  logic [DataWidth-1:0]   wdata;
  logic [IdWidth-1:0]     aid;
  logic                   rvalid;
  logic                   rready;
  logic [DataWidth-1:0]   rdata;
  logic [IdWidth-1:0]     rid;
  logic                   err;

  modport master (
    output req, addr, we, be, wdata, aid, rready,
    input  gnt, rvalid, rdata, rid, err
  );

  modport slave (
    input  req, addr, we, be, wdata, aid, rready,
    output gnt, rvalid, rdata, rid, err
  );
endinterface

// File: rtl/obi_mem_tester.sv
// rtl/obi_mem_tester.sv - OBI memory fill/check engine; OBI_MEM_TESTER_ERR_LOG_EN adds first-error address capture
module obi_mem_tester #(
  parameter int AddrWidth      = 48,
  parameter int DataWidth      = 512,
  parameter int IdWidth        = 3,
  parameter int MaxOutstanding = 2,
  parameter int CntWidth       = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [CntWidth-1:0]  num_words_i,
  input  logic [31:0]          seed_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [CntWidth-1:0]  err_count_o,
  output logic [AddrWidth-1:0] first_err_addr_o,
  obi_mem_tester_if.master     obi
);
  localparam int BeWidth = DataWidth / 8;
  localparam int OffW    = $clog2(BeWidth);
  localparam int Lanes   = DataWidth / 32;
  localparam logic [3:0] MaxOut = 4'(MaxOutstanding);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_CHECK, S_DRAIN, S_DONE} state_e;
  state_e state_q, state_d;

  logic [AddrWidth-1:0] base_q;
  logic [CntWidth-1:0]  num_q, issue_idx_q, rsp_idx_q, err_cnt_q;
  logic [31:0]          seed_q;
  logic                 phase_fill_q, chain_q, done_q, error_q;
  logic [3:0]           out_q;

  logic                 issue, rsp, last_issue, rsp_bad;
  logic [AddrWidth-1:0] issue_addr;
  logic [DataWidth-1:0] issue_pat, rsp_pat;

  function automatic logic [DataWidth-1:0] word_pattern(input logic [31:0] seed,
                                                         input logic [CntWidth-1:0] idx);
    logic [DataWidth-1:0] p;
    logic [31:0]          lane_base;
    lane_base = seed + 32'(idx) * 32'(Lanes);
    for (int l = 0; l < Lanes; l++) p[l*32 +: 32] = lane_base + 32'(l);
    return p;
  endfunction

  assign issue      = obi.req & obi.gnt;
  assign rsp        = obi.rvalid & (out_q != 4'd0);
  assign last_issue = issue & (issue_idx_q == num_q - CntWidth'(1));
  assign issue_pat  = word_pattern(seed_q, issue_idx_q);
  assign rsp_pat    = word_pattern(seed_q, rsp_idx_q);
  // Write responses only carry err; read responses are also compared to the expected pattern.
  assign rsp_bad    = obi.err | (~phase_fill_q & (obi.rdata != rsp_pat));
  assign issue_addr = base_q + (AddrWidth'(issue_idx_q) << OffW);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (num_words_i == '0)    state_d = S_DONE;
          else if (mode_i == 2'd1)  state_d = S_CHECK;
          else                      state_d = S_FILL;
        end
      end
      S_FILL, S_CHECK: if (last_issue) state_d = S_DRAIN;
      S_DRAIN: begin
        if (out_q == 4'd0) state_d = (phase_fill_q && chain_q) ? S_CHECK : S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    obi.req   = 1'b0;
    obi.we    = 1'b0;
    obi.wdata = '0;
    obi.addr  = issue_addr;
    obi.aid   = IdWidth'(issue_idx_q);
    busy_o    = 1'b0;
    case (state_q)
      S_FILL: begin
        busy_o    = 1'b1;
        obi.req   = (out_q < MaxOut);
        obi.we    = 1'b1;
        obi.wdata = issue_pat;
      end
      S_CHECK: begin
        busy_o  = 1'b1;
        obi.req = (out_q < MaxOut);
      end
      S_DRAIN: busy_o = 1'b1;
      default: ;
    endcase
  end

  assign obi.be      = '1;
  assign obi.rready  = 1'b1;
  assign done_o      = done_q | (state_q == S_DONE);
  assign error_o     = error_q;
  assign err_count_o = err_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q       <= '0;
      num_q        <= '0;
      seed_q       <= '0;
      phase_fill_q <= 1'b0;
      chain_q      <= 1'b0;
      issue_idx_q  <= '0;
      rsp_idx_q    <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_cnt_q    <= '0;
      out_q        <= 4'd0;
    end else begin
      if (state_q == S_IDLE && start_i) begin
        base_q       <= base_addr_i & ~AddrWidth'(BeWidth - 1);
        num_q        <= num_words_i;
        seed_q       <= seed_i;
        phase_fill_q <= (mode_i != 2'd1);
        chain_q      <= mode_i[1];
        issue_idx_q  <= '0;
        rsp_idx_q    <= '0;
        done_q       <= 1'b0;
        error_q      <= 1'b0;
        err_cnt_q    <= '0;
      end
      // Fill has fully drained here, so the check pass restarts word numbering from zero.
      if (state_q == S_DRAIN && state_d == S_CHECK) begin
        phase_fill_q <= 1'b0;
        issue_idx_q  <= '0;
        rsp_idx_q    <= '0;
      end
      if (issue) issue_idx_q <= issue_idx_q + CntWidth'(1);
      if (rsp) begin
        rsp_idx_q <= rsp_idx_q + CntWidth'(1);
        if (rsp_bad) begin
          error_q <= 1'b1;
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CntWidth'(1);
        end
      end
      case ({issue, rsp})
        2'b10:   out_q <= out_q + 4'd1;
        2'b01:   out_q <= out_q - 4'd1;
        default: ;
      endcase
      if (state_q == S_DONE) done_q <= 1'b1;
    end
  end

`ifdef OBI_MEM_TESTER_ERR_LOG_EN
  logic [AddrWidth-1:0] first_err_q, rsp_addr;
  assign rsp_addr = base_q + (AddrWidth'(rsp_idx_q) << OffW);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                           first_err_q <= '0;
    else if (state_q == S_IDLE && start_i) first_err_q <= '0;
    else if (rsp && rsp_bad && !error_q)   first_err_q <= rsp_addr;
  end

  assign first_err_addr_o = first_err_q;
`else
  assign first_err_addr_o = '0;
`endif
endmodule

// File: tb/tb_obi_mem_tester.sv
// tb/tb_obi_mem_tester.sv - directed table-driven bench for obi_mem_tester
module tb_obi_mem_tester;
  localparam int AW = 48;
  localparam int DW = 512;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [AW-1:0] base = '0;
  logic [31:0]   num = '0;
  logic [31:0]   seed = '0;
  logic          busy, done, error;
  logic [31:0]   err_count;
  logic [AW-1:0] first_err;

  obi_mem_tester_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) obi ();

  obi_mem_tester dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode),
    .base_addr_i(base), .num_words_i(num), .seed_i(seed),
    .busy_o(busy), .done_o(done), .error_o(error),
    .err_count_o(err_count), .first_err_addr_o(first_err), .obi(obi)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] tb_pat(input logic [31:0] s, input int k);
    logic [DW-1:0] p;
    for (int l = 0; l < DW/32; l++) p[l*32 +: 32] = s + 32'(k) * 32'd16 + 32'(l);
    return p;
  endfunction

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic          err;
  } rsp_t;

  rsp_t          rq[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [AW-1:0] cur_base = '0;
  logic [31:0]   cur_seed = '0;
  int cur_lat = 0, cur_stall = 0, cur_corrupt = -1, cur_err_at = -1;
  int wr_cnt = 0, rd_cnt = 0, g_cnt = 0, req_err = 0, ov_err = 0, stab_err = 0;
  int max_out = 0, tb_out = 0, req_cycles = 0, same_cycle = 0, stall_cnt = 0, cyc = 0;
  logic force_rv = 1'b0;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wdata;
  logic          hold_we;
  logic [IW-1:0] hold_aid;

  initial begin
    obi.gnt = 1'b0; obi.rvalid = 1'b0; obi.rdata = '0; obi.rid = '0; obi.err = 1'b0;
  end

  // Subordinate model: decides gnt/rvalid at negedge, so each decision commits at the next posedge.
  always @(negedge clk) begin
    int idx, g, rv;
    logic [AW-1:0] ea;
    logic [DW-1:0] d;
    rsp_t r;
    cyc++;
    if (!rst_n) begin
      rq.delete(); stall_cnt = 0; tb_out = 0;
      obi.gnt = 1'b0; obi.rvalid = 1'b0; obi.err = 1'b0; obi.rdata = '0; obi.rid = '0;
    end else begin
      if (obi.req) req_cycles++;
      if (obi.req && tb_out >= 2) ov_err++;
      rv = 0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        obi.rvalid = 1'b1; obi.rdata = r.data; obi.rid = r.id; obi.err = r.err; rv = 1;
      end else begin
        obi.rvalid = force_rv; obi.err = force_rv; obi.rdata = force_rv ? '1 : '0;
      end
      g = 0;
      if (obi.req) begin
        if (stall_cnt > 0 && (obi.addr !== hold_addr || obi.wdata !== hold_wdata ||
                              obi.we !== hold_we || obi.aid !== hold_aid)) stab_err++;
        if (stall_cnt < cur_stall) begin
          if (stall_cnt == 0) begin
            hold_addr = obi.addr; hold_wdata = obi.wdata; hold_we = obi.we; hold_aid = obi.aid;
          end
          stall_cnt++;
        end else begin
          stall_cnt = 0;
          g = 1;
          idx = obi.we ? wr_cnt : rd_cnt;
          ea = cur_base + 48'(idx) * 48'd64;
          if (obi.addr !== ea) req_err++;
          if (obi.be !== '1) req_err++;
          if (obi.aid !== 3'(idx)) req_err++;
          if (obi.we) begin
            if (obi.wdata !== tb_pat(cur_seed, idx)) req_err++;
            mem[obi.addr] = obi.wdata;
            d = '0;
            wr_cnt++;
          end else begin
            if (obi.wdata !== '0) req_err++;
            d = mem.exists(obi.addr) ? mem[obi.addr] : '0;
            if (rd_cnt == cur_corrupt) d[0] = ~d[0];
            rd_cnt++;
          end
          rq.push_back('{cyc + 1 + cur_lat, d, obi.aid, (g_cnt == cur_err_at)});
          g_cnt++;
        end
      end else if (stall_cnt > 0) begin
        stab_err++;
        stall_cnt = 0;
      end
      obi.gnt = (g != 0);
      if (g != 0 && rv != 0) same_cycle++;
      tb_out = tb_out + g - rv;
      if (tb_out > max_out) max_out = tb_out;
    end
  end

  typedef struct {
    logic [1:0]    mode;
    logic [AW-1:0] base;
    logic [31:0]   num;
    logic [31:0]   seed;
    int            lat;
    int            stall;
    int            corrupt;
    int            err_at;
    int            exp_w;
    int            exp_r;
    int            exp_cnt;
    logic [AW-1:0] exp_first;
  } vec_t;

  vec_t vecs[8];

  task automatic run_op(input vec_t v, input string tag);
    bit got_done;
    logic [AW-1:0] ef;
    @(negedge clk); #1;
    mem.delete();
    cur_base = v.base & ~48'h3F; cur_seed = v.seed; cur_lat = v.lat; cur_stall = v.stall;
    cur_corrupt = v.corrupt; cur_err_at = v.err_at;
    wr_cnt = 0; rd_cnt = 0; g_cnt = 0; req_err = 0; ov_err = 0; stab_err = 0; max_out = 0; req_cycles = 0;
    if (v.mode == 2'd1)
      for (int k = 0; k < int'(v.num); k++) mem[cur_base + 48'(k) * 48'd64] = tb_pat(v.seed, k);
    mode = v.mode; base = v.base; num = v.num; seed = v.seed; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin got_done = 1'b1; break; end
      @(negedge clk); #1;
    end
    check({tag, "_done_seen"}, got_done, 1'b1);
    @(negedge clk); #1;
`ifdef OBI_MEM_TESTER_ERR_LOG_EN
    ef = v.exp_first;
`else
    ef = '0;
`endif
    check({tag, "_done_sticky"}, done, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_writes"}, 64'(wr_cnt), 64'(v.exp_w));
    check({tag, "_reads"}, 64'(rd_cnt), 64'(v.exp_r));
    check({tag, "_err_count"}, err_count, 64'(v.exp_cnt));
    check({tag, "_error"}, error, (v.exp_cnt != 0));
    check({tag, "_first_err_addr"}, first_err, ef);
    check({tag, "_req_fields"}, 64'(req_err), 64'd0);
    check({tag, "_outstanding_limit"}, 64'(ov_err), 64'd0);
    check({tag, "_max_outstanding_le2"}, (max_out <= 2), 1'b1);
    check({tag, "_stable_while_stalled"}, 64'(stab_err), 64'd0);
  endtask

  initial begin
    vecs[0] = '{2'd2, 48'h1000,          32'd4, 32'h0,        0, 0, -1, -1, 4, 4, 0, 48'h0};
    vecs[1] = '{2'd1, 48'h2000,          32'd2, 32'h5,        0, 0,  1, -1, 0, 2, 1, 48'h2040};
    vecs[2] = '{2'd2, 48'h3000,          32'd6, 32'h100,      5, 0, -1, -1, 6, 6, 0, 48'h0};
    vecs[3] = '{2'd0, 48'h4000,          32'd3, 32'h7,        0, 0, -1,  1, 3, 0, 1, 48'h4040};
    vecs[4] = '{2'd0, 48'h0,             32'd0, 32'h0,        0, 0, -1, -1, 0, 0, 0, 48'h0};
    vecs[5] = '{2'd3, 48'h5023,          32'd2, 32'h9,        0, 3, -1, -1, 2, 2, 0, 48'h0};
    vecs[6] = '{2'd2, 48'hFFFF_FFFF_FFC0, 32'd3, 32'hFFFF_FFF0, 1, 1, -1, -1, 3, 3, 0, 48'h0};
    vecs[7] = '{2'd2, 48'h6000,          32'd4, 32'h33,       2, 0,  2, -1, 4, 4, 1, 48'h6080};

    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_err_count", err_count, 64'd0);
    check("rst_first_err", first_err, 64'd0);
    check("rst_req", obi.req, 1'b0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i));
    check("gnt_rvalid_same_cycle_seen", (same_cycle > 0), 1'b1);

    // Zero-length run: done two cycles after the start pulse, no request ever raised.
    @(negedge clk); #1;
    req_cycles = 0;
    mode = 2'd2; num = 32'd0; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    check("zero_done_2cyc", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    check("zero_no_req", 64'(req_cycles), 64'd0);

    // Reset in the middle of a fill.
    @(negedge clk); #1;
    cur_base = 48'h7000; cur_seed = 32'h1; cur_lat = 5; cur_stall = 0; cur_corrupt = -1; cur_err_at = -1;
    wr_cnt = 0; rd_cnt = 0; g_cnt = 0;
    mode = 2'd0; base = 48'h7000; num = 32'd8; seed = 32'h1; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("midfill_busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("midfill_rst_req", obi.req, 1'b0);
    check("midfill_rst_busy", busy, 1'b0);
    check("midfill_rst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    run_op(vecs[0], "post_reset");

    // Stray rvalid while idle with nothing outstanding must not count.
    @(negedge clk); #1;
    force_rv = 1'b1;
    @(negedge clk); #1;
    force_rv = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("stray_rvalid_error", error, 1'b0);
    check("stray_rvalid_count", err_count, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/obi_mem_tester.md
OBI_MEM_TESTER -- requirements
Module: obi_mem_tester

Interface
REQ-001 SHALL have parameter AddrWidth, default 48, byte address width of the OBI manager port.
REQ-002 SHALL have parameter DataWidth, default 512, OBI data width; a multiple of 32.
REQ-003 SHALL have parameter IdWidth, default 3, OBI aid/rid width.
REQ-004 SHALL have parameter MaxOutstanding, default 2, maximum granted requests without a response; legal range 1..15.
REQ-005 SHALL have parameter CntWidth, default 32, width of the word count and the error count.
REQ-006 clk_i  in  1  single clock; reset is asynchronous and active-low.
REQ-007 rst_ni  in  1  asynchronous active-low reset.
REQ-008 start_i  in  1  launch pulse; sampled only in IDLE.
REQ-009 mode_i  in  2  operation: 0 fill, 1 check, 2 fill-then-check; 3 behaves as 2.
REQ-010 base_addr_i  in  AddrWidth  start byte address; low log2(DataWidth/8) bits treated as 0.
REQ-011 num_words_i  in  CntWidth  number of DataWidth words to process.
REQ-012 seed_i  in  32  pattern seed.
REQ-013 busy_o  out  1; done_o  out  1, sticky; error_o  out  1, sticky; err_count_o  out  CntWidth; first_err_addr_o  out  AddrWidth.
REQ-014 OBI manager: obi_req_o out 1, obi_gnt_i in 1, obi_addr_o out AddrWidth, obi_we_o out 1, obi_be_o out DataWidth/8, obi_wdata_o out DataWidth, obi_aid_o out IdWidth, obi_rvalid_i in 1, obi_rready_o out 1, obi_rdata_i in DataWidth, obi_rid_i in IdWidth, obi_err_i in 1.

Function
REQ-015 SHALL run FSM states IDLE, FILL, CHECK, DRAIN, DONE.
REQ-016 IDLE + start_i: latch inputs, clear done_o/error_o/err_count_o/first_err_addr_o, go to FILL (mode 0/2/3) or CHECK (mode 1); obi_req_o first asserted the next cycle.
REQ-017 num_words_i == 0 with start_i: go directly to DONE, no OBI request issued.
REQ-018 Word k address = base + k*DataWidth/8, modulo 2^AddrWidth (wrap silently).
REQ-019 Word k pattern: 32-bit lane l = seed + k*(DataWidth/32) + l, modulo 2^32.
REQ-020 FILL issues writes (we=1, be all ones, wdata = pattern); CHECK issues reads (we=0, be all ones, wdata 0).
REQ-021 obi_req_o SHALL assert only when outstanding count < MaxOutstanding; once asserted, req/addr/we/wdata/aid stable until obi_gnt_i.
REQ-022 obi_aid_o = k modulo 2^IdWidth; obi_rready_o tied 1.
REQ-023 Outstanding counter: +1 on req&gnt, -1 on rvalid; both same cycle leaves it unchanged.
REQ-024 After last grant in a phase, go to DRAIN; leave DRAIN when counter is 0: to CHECK if mode 2/3 after FILL, else DONE.
REQ-025 Read response j (in grant order) mismatching word j pattern, or any response with obi_err_i, increments err_count_o (saturating) and sets error_o.
REQ-026 DONE: done_o=1, busy_o=0, return to IDLE next cycle; done_o/error_o/counts held until next accepted start.
REQ-027 busy_o = 1 in FILL, CHECK, DRAIN; start_i ignored while busy.
REQ-028 obi_rvalid_i with counter 0 SHALL be ignored.

Reset
REQ-029 Reset, including mid-operation: state IDLE, counter 0, all outputs 0, obi_req_o 0 immediately; in-flight responses after reset ignored.

Configuration
REQ-030 Macro OBI_MEM_TESTER_ERR_LOG_EN defined: first_err_addr_o captures the address of the first erroneous response, held until next start.
REQ-031 Macro undefined: first_err_addr_o constant 0, no address tracking storage; all else unchanged.

Verification
REQ-032 Mode 2, base 0x1000, 4 words, seed 0, zero-latency responder -> 4 writes at 0x1000/0x1040/0x1080/0x10C0, 4 reads, done_o=1, err_count_o=0.
REQ-033 Mode 1, 2 words, responder corrupts word 1 lane 0 -> err_count_o=1, error_o=1, first_err_addr_o=base+0x40 (with macro).
REQ-034 MaxOutstanding 2, responder rvalid delayed 5 cycles -> never more than 2 granted unanswered; gnt and rvalid same cycle keeps count.
REQ-035 num_words_i=0 -> done_o two cycles after start_i, obi_req_o never asserted.
REQ-036 gnt withheld 3 cycles -> addr/wdata stable; reset asserted mid-FILL -> obi_req_o 0, busy_o 0, new start runs cleanly.
REQ-037 obi_err_i on a write response in mode 0 -> err_count_o=1, error_o=1.
